// File: rtl/sdad_framer_pkg.sv
// Shared types and helpers for the sigma-delta UART framer.
// Optional feature macro: SDAD_FRAMER_CHECKSUM_EN (see sdad_uart_framer).
package sdad_framer_pkg;

   // Framer FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_REQ,
      ST_ACK,
      ST_DRAIN
   } state_e;

   // Default frame header word
   localparam logic [7:0] C_SYNC_WORD_DEFAULT = 8'hA5;

   // Number of UART words needed to carry one sample
   function automatic int unsigned f_num_words(input int unsigned sample_w,
                                               input int unsigned uart_w);
      return (sample_w + uart_w - 1) / uart_w;
   endfunction

endpackage

// File: rtl/sdad_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/level.
// A write while full is accepted only when a read frees a slot in the same cycle.
module sdad_sync_fifo #(
   parameter int unsigned G_WIDTH = 16,
   parameter int unsigned G_DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [G_WIDTH-1:0]         wr_data,
   input  logic                       rd_en,
   output logic [G_WIDTH-1:0]         rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(G_DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(G_DEPTH);

   logic [G_WIDTH-1:0] mem_q [G_DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]        level_q, level_d;
   logic               wr_ok;
   logic               rd_ok;

   assign full    = (level_q == (AW+1)'(G_DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Pointer and occupancy update
   always_comb begin
      rd_ok    = rd_en && !empty;
      wr_ok    = wr_en && (!full || rd_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_ok, rd_ok})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array (contents are don't-care while empty)
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/sdad_uart_framer.sv
// Packs decimator samples into UART frames: SYNC word, then sample bytes MSB first.
// Define SDAD_FRAMER_CHECKSUM_EN to append an XOR checksum of the sample bytes.
module sdad_uart_framer
   import sdad_framer_pkg::*;
#(
   parameter int unsigned C_SAMPLE_WIDTH    = 16,
   parameter int unsigned C_UART_DATA_WIDTH = 8,
   parameter int unsigned C_FIFO_DEPTH      = 16,
   parameter logic [C_UART_DATA_WIDTH-1:0] C_SYNC_WORD = C_UART_DATA_WIDTH'(C_SYNC_WORD_DEFAULT),
   parameter int unsigned C_ACK_TIMEOUT     = 1024
) (
   input  logic                              clk,
   input  logic                              rstb,
   input  logic                              enable,
   input  logic [C_SAMPLE_WIDTH-1:0]         sample,
   input  logic                              sampleValid,
   input  logic                              clr,
   output logic [C_UART_DATA_WIDTH-1:0]      txData,
   output logic                              txSend,
   input  logic                              txBusy,
   input  logic                              txErr,
   output logic [$clog2(C_FIFO_DEPTH):0]     fifoLevel,
   output logic                              overflow,
   output logic                              frameErr
);

   localparam int unsigned NB  = f_num_words(C_SAMPLE_WIDTH, C_UART_DATA_WIDTH);
   localparam int unsigned SRW = NB * C_UART_DATA_WIDTH;
`ifdef SDAD_FRAMER_CHECKSUM_EN
   localparam int unsigned NW  = NB + 1;
`else
   localparam int unsigned NW  = NB;
`endif
   localparam int unsigned CW  = $clog2(NW + 1);
   localparam int unsigned TW  = $clog2(C_ACK_TIMEOUT + 1);

   state_e                        state_q, state_d;
   logic [C_UART_DATA_WIDTH-1:0]  txData_q, txData_d;
   logic                          txSend_q, txSend_d;
   logic [SRW-1:0]                sreg_q, sreg_d;
   logic [CW-1:0]                 word_cnt_q, word_cnt_d;
   logic [TW-1:0]                 tmo_q, tmo_d;
   logic                          overflow_q, overflow_d;
   logic                          frameErr_q, frameErr_d;
`ifdef SDAD_FRAMER_CHECKSUM_EN
   logic [C_UART_DATA_WIDTH-1:0]  csum_q, csum_d;
`endif

   logic                          pop;
   logic                          drop;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [C_SAMPLE_WIDTH-1:0]     fifo_rd_data;
   logic [C_UART_DATA_WIDTH-1:0]  next_byte;

   sdad_sync_fifo #(
      .G_WIDTH (C_SAMPLE_WIDTH),
      .G_DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rstb),
      .wr_en   (sampleValid),
      .wr_data (sample),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifoLevel)
   );

   assign txData   = txData_q;
   assign txSend   = txSend_q;
   assign overflow = overflow_q;
   assign frameErr = frameErr_q;
   assign next_byte = sreg_q[SRW-1 -: C_UART_DATA_WIDTH];

   // Next-state, handshake and sticky-flag logic
   always_comb begin
      state_d    = state_q;
      txData_d   = txData_q;
      txSend_d   = 1'b0;
      sreg_d     = sreg_q;
      word_cnt_d = word_cnt_q;
      tmo_d      = tmo_q;
      pop        = 1'b0;
`ifdef SDAD_FRAMER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      // Clear first so a same-cycle set below takes precedence
      overflow_d = clr ? 1'b0 : overflow_q;
      frameErr_d = clr ? 1'b0 : frameErr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (enable && !fifo_empty && !txBusy) state_d = ST_POP;
         end
         ST_POP: begin
            pop        = 1'b1;
            sreg_d     = SRW'(fifo_rd_data);
            word_cnt_d = '0;
            tmo_d      = '0;
            txData_d   = C_SYNC_WORD;
`ifdef SDAD_FRAMER_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = ST_REQ;
         end
         ST_REQ: begin
            if (txErr || (!txBusy && tmo_q == TW'(C_ACK_TIMEOUT - 1))) begin
               // Abort: mark all words consumed so DRAIN returns to IDLE
               frameErr_d = 1'b1;
               word_cnt_d = CW'(NW);
               state_d    = ST_ACK;
            end else if (txBusy) begin
               state_d = ST_ACK;
            end else begin
               tmo_d    = tmo_q + TW'(1);
               txSend_d = 1'b1;
            end
         end
         ST_ACK: begin
            if (txErr) begin
               frameErr_d = 1'b1;
               word_cnt_d = CW'(NW);
            end
            if (!txBusy) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (word_cnt_q < CW'(NB)) begin
               txData_d   = next_byte;
               sreg_d     = sreg_q << C_UART_DATA_WIDTH;
               word_cnt_d = word_cnt_q + CW'(1);
               tmo_d      = '0;
`ifdef SDAD_FRAMER_CHECKSUM_EN
               csum_d     = csum_q ^ next_byte;
`endif
               state_d    = ST_REQ;
`ifdef SDAD_FRAMER_CHECKSUM_EN
            end else if (word_cnt_q == CW'(NB)) begin
               txData_d   = csum_q;
               word_cnt_d = word_cnt_q + CW'(1);
               tmo_d      = '0;
               state_d    = ST_REQ;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      drop = sampleValid && fifo_full && !pop;
      if (drop) overflow_d = 1'b1;
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q    <= ST_IDLE;
         txData_q   <= '0;
         txSend_q   <= 1'b0;
         sreg_q     <= '0;
         word_cnt_q <= '0;
         tmo_q      <= '0;
         overflow_q <= 1'b0;
         frameErr_q <= 1'b0;
`ifdef SDAD_FRAMER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         txData_q   <= txData_d;
         txSend_q   <= txSend_d;
         sreg_q     <= sreg_d;
         word_cnt_q <= word_cnt_d;
         tmo_q      <= tmo_d;
         overflow_q <= overflow_d;
         frameErr_q <= frameErr_d;
`ifdef SDAD_FRAMER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_sdad_uart_framer.sv
// Directed bench for sdad_uart_framer with a UART_Tx behavioural model and word scoreboard.
module tb_sdad_uart_framer;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] sample = '0;
   logic        sampleValid = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  txData;
   logic        txSend;
   logic        txBusy = 1'b0;
   logic        txErr = 1'b0;
   logic [4:0]  fifoLevel;
   logic        overflow;
   logic        frameErr;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] sb[$];
   int  busy_cnt   = 0;
   int  busy_clks  = 100;
   int  captured   = 0;
   bit  stall      = 1'b0;
   bit  never_busy = 1'b0;

   always #5 clk = ~clk;

   sdad_uart_framer #(
      .C_SAMPLE_WIDTH    (16),
      .C_UART_DATA_WIDTH (8),
      .C_FIFO_DEPTH      (16),
      .C_SYNC_WORD       (8'hA5),
      .C_ACK_TIMEOUT     (1024)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .enable      (enable),
      .sample      (sample),
      .sampleValid (sampleValid),
      .clr         (clr),
      .txData      (txData),
      .txSend      (txSend),
      .txBusy      (txBusy),
      .txErr       (txErr),
      .fifoLevel   (fifoLevel),
      .overflow    (overflow),
      .frameErr    (frameErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // UART_Tx model: accepts a word when idle and txSend is high, then stays busy
   always @(negedge clk) begin
      if (stall) begin
         txBusy = 1'b1;
      end else if (busy_cnt != 0) begin
         busy_cnt--;
         txBusy = (busy_cnt != 0);
      end else begin
         txBusy = 1'b0;
         if (txSend && !never_busy) begin
            captured++;
            if (sb.size() == 0) chk("tx_word_extra", {24'b0, txData}, 32'hFFFF_FFFF);
            else                chk("tx_word", {24'b0, txData}, {24'b0, sb.pop_front()});
            busy_cnt = busy_clks;
            txBusy   = 1'b1;
         end
      end
   end

   task automatic expect_frame(input logic [15:0] v);
      sb.push_back(8'hA5);
      sb.push_back(v[15:8]);
      sb.push_back(v[7:0]);
`ifdef SDAD_FRAMER_CHECKSUM_EN
      sb.push_back(v[15:8] ^ v[7:0]);
`endif
   endtask

   task automatic send_sample(input logic [15:0] v);
      @(negedge clk);
      sample      = v;
      sampleValid = 1'b1;
      @(negedge clk);
      sampleValid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (n < bound && !(sb.size() == 0 && !txBusy && !txSend && fifoLevel == 0)) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", {31'b0, n < bound}, 32'd1);
      repeat (10) @(negedge clk);
   endtask

   task automatic wait_captured(input int target, input int bound);
      int n = 0;
      while (n < bound && captured < target) begin
         @(negedge clk);
         n++;
      end
      chk("capture_wait", {31'b0, captured >= target}, 32'd1);
   endtask

   initial begin
      int n;
      int c;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_txSend",    {31'b0, txSend},    32'd0);
      chk("rst_txData",    {24'b0, txData},    32'd0);
      chk("rst_fifoLevel", {27'b0, fifoLevel}, 32'd0);
      chk("rst_overflow",  {31'b0, overflow},  32'd0);
      chk("rst_frameErr",  {31'b0, frameErr},  32'd0);
      @(negedge clk);
      rstb = 1'b1;
      repeat (2) @(negedge clk);

      // Single sample with latency measurement
      expect_frame(16'h1234);
      sample      = 16'h1234;
      sampleValid = 1'b1;
      @(posedge clk);
      #1;
      sampleValid = 1'b0;
      chk("lat_level", {27'b0, fifoLevel}, 32'd1);
      n = 0;
      while (n < 10 && !txSend) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, 32'd3);
      wait_idle(2000);
      chk("single_level",    {27'b0, fifoLevel}, 32'd0);
      chk("single_frameErr", {31'b0, frameErr},  32'd0);

      // enable low holds the sample in the FIFO
      enable = 1'b0;
      send_sample(16'h00FF);
      repeat (20) @(negedge clk);
      chk("disabled_level",  {27'b0, fifoLevel}, 32'd1);
      chk("disabled_txSend", {31'b0, txSend},    32'd0);
      expect_frame(16'h00FF);
      enable = 1'b1;
      wait_idle(2000);

      // Overflow: 17 samples while Tx is stalled
      stall = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) expect_frame(16'h1000 + 16'(i * 16'h0111));
         sample      = 16'h1000 + 16'(i * 16'h0111);
         sampleValid = 1'b1;
         @(negedge clk);
      end
      sampleValid = 1'b0;
      chk("ovf_level", {27'b0, fifoLevel}, 32'd16);
      chk("ovf_flag",  {31'b0, overflow},  32'd1);
      stall = 1'b0;
      wait_idle(12000);
      chk("ovf_sticky", {31'b0, overflow}, 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("ovf_clr", {31'b0, overflow}, 32'd0);

      // Ack timeout: Tx never raises busy
      never_busy = 1'b1;
      send_sample(16'h5555);
      n = 0;
      while (n < 20 && !txSend) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("tmo_send_seen", {31'b0, txSend}, 32'd1);
      n = 0;
      while (n < 1200 && !frameErr) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("tmo_clks",     n, 32'd1023);
      chk("tmo_frameErr", {31'b0, frameErr}, 32'd1);
      chk("tmo_txSend",   {31'b0, txSend},   32'd0);
      never_busy = 1'b0;
      repeat (5) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("tmo_clr", {31'b0, frameErr}, 32'd0);
      expect_frame(16'hC3C3);
      send_sample(16'hC3C3);
      wait_idle(2000);

      // txErr during the first sample byte, coincident with clr
      c = captured;
      sb.push_back(8'hA5);
      sb.push_back(8'hBE);
      send_sample(16'hBEEF);
      wait_captured(c + 2, 1000);
      @(negedge clk);
      txErr = 1'b1;
      clr   = 1'b1;
      @(negedge clk);
      txErr = 1'b0;
      clr   = 1'b0;
      chk("err_set_wins", {31'b0, frameErr}, 32'd1);
      wait_idle(2000);
      chk("err_frameErr", {31'b0, frameErr}, 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("err_clr", {31'b0, frameErr}, 32'd0);

      // Reset while waiting for the Tx to finish a word
      c = captured;
      sb.push_back(8'hA5);
      send_sample(16'h7777);
      wait_captured(c + 1, 1000);
      @(posedge clk);
      @(negedge clk);
      rstb = 1'b0;
      #1;
      chk("mid_rst_txSend",    {31'b0, txSend},    32'd0);
      chk("mid_rst_txData",    {24'b0, txData},    32'd0);
      chk("mid_rst_fifoLevel", {27'b0, fifoLevel}, 32'd0);
      chk("mid_rst_overflow",  {31'b0, overflow},  32'd0);
      chk("mid_rst_frameErr",  {31'b0, frameErr},  32'd0);
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      expect_frame(16'h1234);
      send_sample(16'h1234);
      wait_idle(2000);
      chk("sb_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
